// File: rtl/spi_sector_erase_ctrl.sv
// Sector-erase sequencer for a byte-level SPI master: WREN, SECTOR ERASE, then RDSR polling until WIP clears.
// Define SE_TIMEOUT_EN to bound the number of status polls and report a timeout through err.
module spi_sector_erase_ctrl #(
    parameter int unsigned PWRUP_WAIT    = 100,
    parameter int unsigned CS_GAP        = 10,
    parameter int unsigned POLL_GAP      = 50,
    parameter logic [15:0] TIMEOUT_POLLS = 16'd60000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        erase_req,
    input  logic [23:0] erase_addr,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        spi_start,
    output logic        spi_end,
    output logic [7:0]  data_send,
    input  logic        send_done,
    input  logic [7:0]  data_rec
);

    typedef enum logic [3:0] {
        PWRUP,
        READY,
        WREN,
        GAP1,
        SE,
        GAP2,
        RDSR,
        PGAP,
        FIN
    } state_t;

    localparam logic [31:0] PWRUP_LEN = 32'(PWRUP_WAIT);
    localparam logic [31:0] CS_LEN    = 32'(CS_GAP);
    localparam logic [31:0] POLL_LEN  = 32'(POLL_GAP);

    state_t      state;
    state_t      state_next;
    logic [31:0] cnt;
    logic [31:0] gap_len;
    logic        gap_hit;
    logic        gap_state;
    logic [1:0]  byte_idx;
    logic [1:0]  byte_idx_next;
    logic        sent;
    logic        sent_next;
    logic [23:0] addr_q;
    logic        accept;
    logic        frame_done;
    logic        poll_limit;

    // Length of the wait in the current counting state; the counter restarts at zero on every state entry.
    always_comb begin
        gap_len = 32'd0;
        case (state)
            PWRUP:      gap_len = PWRUP_LEN;
            GAP1, GAP2: gap_len = CS_LEN;
            PGAP:       gap_len = POLL_LEN;
            default:    gap_len = 32'd0;
        endcase
    end

    assign gap_hit   = (cnt + 32'd1) >= gap_len;
    assign gap_state = (state == PWRUP) || (state == GAP1) || (state == GAP2) || (state == PGAP);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= PWRUP;
            cnt      <= '0;
            byte_idx <= '0;
            sent     <= 1'b0;
            addr_q   <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                cnt      <= '0;
                byte_idx <= '0;
                sent     <= 1'b0;
            end else begin
                if (gap_state) begin
                    cnt <= cnt + 32'd1;
                end
                byte_idx <= byte_idx_next;
                sent     <= sent_next;
            end
            if (accept) begin
                addr_q <= erase_addr;
            end
        end
    end

    // In byte states, 'sent' marks a byte in flight: spi_start fires only while it is clear,
    // spi_end only on a send_done while it is set, so the two can never coincide.
    always_comb begin
        state_next    = state;
        byte_idx_next = byte_idx;
        sent_next     = sent;
        spi_start     = 1'b0;
        spi_end       = 1'b0;
        data_send     = 8'h00;
        accept        = 1'b0;
        frame_done    = 1'b0;
        case (state)
            PWRUP: begin
                if (gap_hit) begin
                    state_next = READY;
                end
            end
            READY: begin
                if (erase_req) begin
                    accept     = 1'b1;
                    state_next = WREN;
                end
            end
            WREN: begin
                if (!sent) begin
                    spi_start = 1'b1;
                    data_send = 8'h06;
                    sent_next = 1'b1;
                end else if (send_done) begin
                    spi_end    = 1'b1;
                    state_next = GAP1;
                end
            end
            GAP1: begin
                if (gap_hit) begin
                    state_next = SE;
                end
            end
            SE: begin
                if (!sent) begin
                    spi_start = 1'b1;
                    sent_next = 1'b1;
                    case (byte_idx)
                        2'd0:    data_send = 8'hD8;
                        2'd1:    data_send = addr_q[23:16];
                        2'd2:    data_send = addr_q[15:8];
                        default: data_send = addr_q[7:0];
                    endcase
                end else if (send_done) begin
                    if (byte_idx == 2'd3) begin
                        spi_end    = 1'b1;
                        state_next = GAP2;
                    end else begin
                        byte_idx_next = byte_idx + 2'd1;
                        sent_next     = 1'b0;
                    end
                end
            end
            GAP2: begin
                if (gap_hit) begin
                    state_next = RDSR;
                end
            end
            RDSR: begin
                if (!sent) begin
                    spi_start = 1'b1;
                    sent_next = 1'b1;
                    data_send = (byte_idx == 2'd0) ? 8'h05 : 8'h00;
                end else if (send_done) begin
                    if (byte_idx == 2'd0) begin
                        byte_idx_next = 2'd1;
                        sent_next     = 1'b0;
                    end else begin
                        spi_end    = 1'b1;
                        frame_done = 1'b1;
                        if (!data_rec[0] || poll_limit) begin
                            state_next = FIN;
                        end else begin
                            state_next = PGAP;
                        end
                    end
                end
            end
            PGAP: begin
                if (gap_hit) begin
                    state_next = RDSR;
                end
            end
            FIN: begin
                state_next = READY;
            end
            default: begin
                state_next = PWRUP;
            end
        endcase
        // A frame cut short by reset must not release CS; the byte master resets itself.
        if (sys_rst) begin
            spi_start = 1'b0;
            spi_end   = 1'b0;
            data_send = 8'h00;
        end
    end

    assign busy = (state != PWRUP) && (state != READY);
    assign done = (state == FIN);

`ifdef SE_TIMEOUT_EN
    logic [15:0] poll_cnt;
    logic        err_flag;

    // One count per completed status frame; the limit is checked against the frame now finishing.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            poll_cnt <= '0;
            err_flag <= 1'b0;
        end else if (accept) begin
            poll_cnt <= '0;
            err_flag <= 1'b0;
        end else if (frame_done) begin
            poll_cnt <= poll_cnt + 16'd1;
            if (data_rec[0] && poll_limit) begin
                err_flag <= 1'b1;
            end
        end
    end

    assign poll_limit = ({1'b0, poll_cnt} + 17'd1) >= {1'b0, TIMEOUT_POLLS};
    assign err        = done && err_flag;
`else
    logic unused_timeout;

    assign poll_limit     = 1'b0;
    assign err            = 1'b0;
    assign unused_timeout = ^{TIMEOUT_POLLS, frame_done};
`endif

    logic unused_rec;
    assign unused_rec = ^data_rec[7:1];

endmodule

// File: doc/spi_sector_erase_ctrl.md
SPI_SECTOR_ERASE_CTRL -- requirements
Module: spi_sector_erase_ctrl

Interface
REQ-001 Parameter PWRUP_WAIT, default 100, sys_clk cycles waited after reset before any request is accepted.
REQ-002 Parameter CS_GAP, default 10, idle cycles between spi_end and the next spi_start.
REQ-003 Parameter POLL_GAP, default 50, idle cycles between two status-read frames.
REQ-004 Parameter TIMEOUT_POLLS, default 16'd60000, maximum status-read frames before timeout (used only under SE_TIMEOUT_EN).
REQ-005 sys_clk  in  1  system clock, 50 MHz; the only clock.
REQ-006 sys_rst  in  1  reset, synchronous, active-high.
REQ-007 erase_req  in  1  one-cycle pulse; starts a sector erase; sampled only in READY.
REQ-008 erase_addr  in  24  sector address; captured on the accepted erase_req.
REQ-009 busy  out  1  high from the accepted request until done.
REQ-010 done  out  1  one-cycle pulse when the erase ends.
REQ-011 err  out  1  valid with done; 1 = timeout.
REQ-012 spi_start  out  1  one-cycle pulse; byte master sends data_send, opening CS if closed.
REQ-013 spi_end  out  1  one-cycle pulse; byte master releases CS.
REQ-014 data_send  out  8  byte to transmit.
REQ-015 send_done  in  1  one-cycle pulse; byte finished.
REQ-016 data_rec  in  8  received byte; valid in the send_done cycle.

Function
REQ-017 The block SHALL have these states: PWRUP, READY, WREN, GAP1, SE (4 bytes), GAP2, RDSR (2 bytes), PGAP, FIN.
REQ-018 In PWRUP the block SHALL count PWRUP_WAIT cycles, then enter READY; an erase_req during PWRUP SHALL be ignored.
REQ-019 In READY, erase_req SHALL capture erase_addr, set busy on the next edge, and enter WREN.
REQ-020 WREN SHALL pulse spi_start with data_send=8'h06; on send_done it SHALL pulse spi_end and enter GAP1.
REQ-021 GAP1 and GAP2 SHALL each wait CS_GAP cycles.
REQ-022 SE SHALL send, in one CS frame, 8'hD8, addr[23:16], addr[15:8], addr[7:0]; the next spi_start SHALL pulse the cycle after each send_done; spi_end SHALL pulse only on the 4th send_done; then enter GAP2.
REQ-023 RDSR SHALL send 8'h05 then 8'h00 in one frame; on the 2nd send_done it SHALL sample data_rec[0] (WIP) and pulse spi_end.
REQ-024 If WIP=1 the block SHALL enter PGAP, wait POLL_GAP cycles, then repeat RDSR; if WIP=0 it SHALL enter FIN.
REQ-025 FIN SHALL pulse done with err=0, clear busy, and return to READY in the same edge.
REQ-026 At most one of spi_start or spi_end SHALL be high in any cycle; no spi_start SHALL occur while a byte is in flight.
REQ-027 A send_done outside a byte-wait state SHALL be ignored.
REQ-028 An erase_req while busy SHALL be dropped; it is not queued.
REQ-029 Gap counters SHALL be 32 bits and cleared on every state entry.

Reset
REQ-030 sys_rst SHALL force PWRUP and zero all counters; busy, done, err, spi_start, spi_end, and data_send SHALL be 0.
REQ-031 sys_rst mid-frame SHALL NOT emit spi_end; the byte master has its own reset.

Configuration
REQ-032 With SE_TIMEOUT_EN defined, a 16-bit poll counter SHALL increment per RDSR frame; when it reaches TIMEOUT_POLLS with WIP=1, the block SHALL pulse done with err=1 and return to READY.
REQ-033 Without SE_TIMEOUT_EN, the block SHALL poll indefinitely; err SHALL be tied to 0 and the poll counter SHALL be absent.

Verification
REQ-034 Reset, then erase_req at cycle 50 -> ignored; busy stays 0.
REQ-035 Erase_req with addr=24'h12_3000 after PWRUP -> bytes 06 | D8 12 30 00 | 05 00 in 3 frames; spi_end counts 1, 1, 1.
REQ-036 Status model returns WIP=1 for 3 polls, then 0 -> 4 RDSR frames spaced ≥ POLL_GAP cycles apart; a single done with err=0.
REQ-037 Second erase_req during SE -> dropped; exactly one done.
REQ-038 SE_TIMEOUT_EN, TIMEOUT_POLLS=5, WIP stuck at 1 -> done with err=1 after the 5th frame; the next request is accepted.
REQ-039 sys_rst asserted during RDSR -> all outputs 0 next edge; PWRUP restarts.
